gpio_in_sync_irq: RTL and testbench
===================================

Name: gpio_in_sync_irq

Overview:
- Input-side stage of the GPIO block. Consumes raw gpio_pin_in and the n_gpio_pin_oe direction mask.
- Synchronises pins into the pclk domain, detects configured edge/level events on input-mode pins, and holds sticky per-pin interrupt status.
- Drives a single registered irq to the APB register block.

Parameters:
- GPIO_DATA_WIDTH, 16, number of GPIO pins.
- SYNC_STAGES, 2, synchroniser flops per pin (legal 2..4).
- DEBOUNCE_CYCLES, 4, stable-sample count required when debounce is compiled in (legal 1..255).

Ports:
- pclk  in  1  clock for all logic.
- p_reset  in  1  synchronous reset, active-high.
- gpio_pin_in  in  GPIO_DATA_WIDTH  raw asynchronous pad inputs.
- n_gpio_pin_oe  in  GPIO_DATA_WIDTH  per-pin output enable, active-low; 1 = pin is an input.
- cfg_int_en  in  GPIO_DATA_WIDTH  per-pin interrupt enable.
- cfg_int_level  in  GPIO_DATA_WIDTH  1 = level-sensitive, 0 = edge-sensitive.
- cfg_int_pol  in  GPIO_DATA_WIDTH  1 = rising/high, 0 = falling/low.
- int_clr  in  GPIO_DATA_WIDTH  one-cycle write-1-to-clear pulses for int_status.
- gpio_sync_in  out  GPIO_DATA_WIDTH  synchronised (and filtered) pin value.
- int_status  out  GPIO_DATA_WIDTH  sticky per-pin interrupt status.
- irq  out  1  registered OR of (int_status & cfg_int_en).

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs, sync flops, prev register and warm-up counter clear to 0 on the first pclk edge with p_reset=1.
- Sync chain: gpio_sync_in = last synchroniser stage. A pin change is visible on gpio_sync_in SYNC_STAGES pclk edges after it is first sampled.
- Previous-value register: prev <= gpio_sync_in each cycle.
  - rise = gpio_sync_in & ~prev; fall = ~gpio_sync_in & prev.
- Warm-up: a counter runs from reset release for SYNC_STAGES+1 cycles. While it is running, event detection is suppressed. No spurious edge is reported for pins already high at reset.
- Event per pin i requires all of:
  - n_gpio_pin_oe[i]=1;
  - cfg_int_en[i]=1;
  - warm-up done;
  - condition: edge mode = rise (pol=1) or fall (pol=0); level mode = sync==pol.
- int_status[i] sets on the pclk edge after the event is present.
  - Latency from first sampling edge to int_status: SYNC_STAGES+1 cycles. irq follows one cycle later.
- Clear: int_clr[i]=1 clears int_status[i] on the next edge.
  - Set and clear in the same cycle: set wins.
  - Level mode with level still active: bit re-sets on every cycle, so clear is ineffective until the level drops.
- Masking: deasserting cfg_int_en[i] does not clear int_status[i]. It removes bit i from irq on the next edge.
- Output-mode pins (n_gpio_pin_oe[i]=0): gpio_sync_in still tracks the pin; no events are generated.
- Config changes mid-operation take effect on the next cycle. A pol change creates no artificial edge, because edges come from sync/prev only.
- Reset mid-operation: all state is lost, including pending status and any partial debounce count. Warm-up restarts.

Optional Feature:
- Macro: GPIO_IN_DEBOUNCE_EN.
- Defined: a per-pin counter sits between the sync chain and gpio_sync_in. Filtered value updates only after DEBOUNCE_CYCLES consecutive identical synchronised samples that differ from the current filtered value. Any mismatch restarts the count, so glitches shorter than DEBOUNCE_CYCLES cycles never reach gpio_sync_in. This adds DEBOUNCE_CYCLES cycles of latency. Warm-up extends by DEBOUNCE_CYCLES.
- Undefined: gpio_sync_in = synchroniser output directly. No counters are instantiated.

Decomposition:
- Package gpio_in_pkg:
  - GPIO_DATA_WIDTH default constant;
  - typedef gpio_vec_t (logic [GPIO_DATA_WIDTH-1:0]);
  - enum int_mode_e {INT_EDGE, INT_LEVEL};
  - localparam computing the warm-up count width.
- Sub-module gpio_in_filter_bit: one pin's synchroniser plus optional debounce counter. Instantiated GPIO_DATA_WIDTH times by generate. Top level holds edge detect, status and irq.

Test Plan:
- Reset with gpio_pin_in=16'hFFFF, all input, int_en=FFFF, edge rising → int_status stays 0 and irq stays 0 through warm-up and 20 further cycles.
- Pin 3 rises 0→1, edge/rising, en[3]=1 → int_status=16'h0008 exactly 3 cycles after the sampling edge; irq=1 one cycle later. int_clr=16'h0008 → status 0 next cycle, irq 0 the cycle after.
- Pin 5 level/high held 1, int_clr[5] pulsed → int_status[5] remains 1. Pin drops to 0, then clear → 0.
- Pin 7 falling edge with n_gpio_pin_oe[7]=0 → gpio_sync_in[7] follows; int_status[7] stays 0. Same edge coincident with int_clr on an input pin → status set wins.
- Status bit 2 set, then cfg_int_en[2]=0 → irq drops next cycle, int_status[2] still 1; re-enable → irq returns.
- With GPIO_IN_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 3-cycle glitch on pin 0 → no change in gpio_sync_in and no status. 6-cycle high → gpio_sync_in[0]=1 after 2+4 cycles; status set.

Source files
------------

// File: rtl/gpio_in_pkg.sv
//------------------------------------------------------------------------------
// Module   : gpio_in_pkg
// Brief    : Shared types, sizing constants and event helper for the GPIO input stage.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package gpio_in_pkg;

    localparam int c_GPIO_DATA_WIDTH     = 16;
    localparam int c_MAX_SYNC_STAGES     = 4;
    localparam int c_MAX_DEBOUNCE_CYCLES = 255;

    // Sized for the longest legal warm-up: max sync depth + 1 + max debounce.
    localparam int c_WARMUP_CNT_W =
        $clog2(c_MAX_SYNC_STAGES + 1 + c_MAX_DEBOUNCE_CYCLES + 1);

    typedef logic [c_GPIO_DATA_WIDTH-1:0] gpio_vec_t;

    typedef enum logic {
        INT_EDGE  = 1'b0,
        INT_LEVEL = 1'b1
    } int_mode_e;

    function automatic logic pin_event_cond(
        input int_mode_e mode,
        input logic      pol,
        input logic      cur,
        input logic      prev
    );
        logic edge_hit;
        edge_hit = pol ? (cur & ~prev) : (~cur & prev);
        return (mode == INT_LEVEL) ? (cur == pol) : edge_hit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_in_filter_bit.sv
//------------------------------------------------------------------------------
// Module   : gpio_in_filter_bit
// Brief    : One pin's synchroniser, plus a debounce filter when
//            GPIO_IN_DEBOUNCE_EN is defined.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gpio_in_filter_bit
    import gpio_in_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_sync
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > c_MAX_SYNC_STAGES ||
        DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > c_MAX_DEBOUNCE_CYCLES) begin : g_bad_param
        $error("gpio_in_filter_bit: SYNC_STAGES or DEBOUNCE_CYCLES out of range");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    assign w_raw = r_sync[SYNC_STAGES-1];

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_filt;

    // r_cnt counts consecutive samples that disagree with the filtered value;
    // any agreeing sample throws the partial run away.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (w_raw == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_filt <= w_raw;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + c_CNT_W'(1);
        end
    end

    assign o_sync = r_filt;
`else
    assign o_sync = w_raw;
`endif

endmodule

`default_nettype wire

// File: rtl/gpio_in_sync_irq.sv
//------------------------------------------------------------------------------
// Module   : gpio_in_sync_irq
// Brief    : GPIO input stage: pin sync, edge/level detect, sticky status, irq.
//            Optional debounce via GPIO_IN_DEBOUNCE_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module gpio_in_sync_irq
    import gpio_in_pkg::*;
#(
    parameter int GPIO_DATA_WIDTH = c_GPIO_DATA_WIDTH,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                       pclk,
    input  logic                       p_reset,
    input  logic [GPIO_DATA_WIDTH-1:0] gpio_pin_in,
    input  logic [GPIO_DATA_WIDTH-1:0] n_gpio_pin_oe,
    input  logic [GPIO_DATA_WIDTH-1:0] cfg_int_en,
    input  logic [GPIO_DATA_WIDTH-1:0] cfg_int_level,
    input  logic [GPIO_DATA_WIDTH-1:0] cfg_int_pol,
    input  logic [GPIO_DATA_WIDTH-1:0] int_clr,
    output logic [GPIO_DATA_WIDTH-1:0] gpio_sync_in,
    output logic [GPIO_DATA_WIDTH-1:0] int_status,
    output logic                       irq
);

    // Detection waits until prev holds a genuine post-reset sample,
    // so pins already high at reset never look like a rising edge.
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int c_WARMUP_CYCLES = SYNC_STAGES + 1 + DEBOUNCE_CYCLES;
`else
    localparam int c_WARMUP_CYCLES = SYNC_STAGES + 1;
`endif
    localparam logic [c_WARMUP_CNT_W-1:0] c_WARMUP_LAST = c_WARMUP_CNT_W'(c_WARMUP_CYCLES);

    logic [c_WARMUP_CNT_W-1:0]  r_warm_cnt;
    logic                       w_warm_done;
    logic [GPIO_DATA_WIDTH-1:0] w_sync;
    logic [GPIO_DATA_WIDTH-1:0] w_cond;
    logic [GPIO_DATA_WIDTH-1:0] w_event;
    logic [GPIO_DATA_WIDTH-1:0] r_prev;
    logic [GPIO_DATA_WIDTH-1:0] r_status;
    logic                       r_irq;

    assign w_warm_done = (r_warm_cnt == c_WARMUP_LAST);

    always_ff @(posedge pclk) begin
        if (p_reset) begin
            r_warm_cnt <= '0;
        end else if (!w_warm_done) begin
            r_warm_cnt <= r_warm_cnt + c_WARMUP_CNT_W'(1);
        end
    end

    for (genvar i = 0; i < GPIO_DATA_WIDTH; i++) begin : g_pin
        gpio_in_filter_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_filter (
            .clk    (pclk),
            .rst    (p_reset),
            .i_pin  (gpio_pin_in[i]),
            .o_sync (w_sync[i])
        );

        assign w_cond[i] = pin_event_cond(int_mode_e'(cfg_int_level[i]),
                                          cfg_int_pol[i], w_sync[i], r_prev[i]);
    end

    assign w_event = n_gpio_pin_oe & cfg_int_en & w_cond
                   & {GPIO_DATA_WIDTH{w_warm_done}};

    // Set dominates clear, so an active level keeps re-asserting its bit.
    always_ff @(posedge pclk) begin
        if (p_reset) begin
            r_prev   <= '0;
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_prev   <= w_sync;
            r_status <= (r_status & ~int_clr) | w_event;
            r_irq    <= |(r_status & cfg_int_en);
        end
    end

    assign gpio_sync_in = w_sync;
    assign int_status   = r_status;
    assign irq          = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_gpio_in_sync_irq.sv
//------------------------------------------------------------------------------
// Module   : tb_gpio_in_sync_irq
// Brief    : Scoreboard bench for gpio_in_sync_irq: directed scenarios then random
//            traffic, every cycle checked against a behavioural pin model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_gpio_in_sync_irq;
    import gpio_in_pkg::*;

    localparam int W    = c_GPIO_DATA_WIDTH;
    localparam int S    = 2;
    localparam int D    = 4;
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int WARM = S + 1 + D;
`else
    localparam int WARM = S + 1;
`endif

    typedef struct packed {
        gpio_vec_t sync;
        gpio_vec_t status;
        logic      irq;
    } exp_t;

    logic      pclk;
    logic      s_rst;
    gpio_vec_t s_pin, s_oe, s_en, s_lvl, s_pol, s_clr;
    gpio_vec_t d_sync, d_status;
    logic      d_irq;

    int n_vec;
    int n_err;

    exp_t q_exp[$];

    gpio_in_sync_irq #(
        .GPIO_DATA_WIDTH (W),
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .pclk          (pclk),
        .p_reset       (s_rst),
        .gpio_pin_in   (s_pin),
        .n_gpio_pin_oe (s_oe),
        .cfg_int_en    (s_en),
        .cfg_int_level (s_lvl),
        .cfg_int_pol   (s_pol),
        .int_clr       (s_clr),
        .gpio_sync_in  (d_sync),
        .int_status    (d_status),
        .irq           (d_irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Reference model state, expressed per clock edge.
    gpio_vec_t m_raw, m_sync, m_prev, m_status, m_filt;
    logic      m_irq;
    int        m_since;
    int        m_run [W];
    gpio_vec_t pin_hist[$];
    bit        rst_hist[$];

    task automatic model_edge();
        gpio_vec_t raw_old, sync_old, raw_new, ev;
        logic      irq_new;
        bit        rst_win, done, hit;
        exp_t      e;
        raw_old  = m_raw;
        sync_old = m_sync;
        pin_hist.push_back(s_pin);
        rst_hist.push_back(s_rst);
        while (pin_hist.size() > S) begin
            void'(pin_hist.pop_front());
            void'(rst_hist.pop_front());
        end
        // A pin sampled at edge k reaches the sync output at edge k+S-1 unless
        // a reset lands anywhere in that window.
        rst_win = 1'b0;
        foreach (rst_hist[j]) if (rst_hist[j]) rst_win = 1'b1;
        raw_new = rst_win ? '0 : pin_hist[0];
        done    = (m_since >= WARM);

        if (s_rst) begin
            m_raw = '0; m_sync = '0; m_prev = '0; m_status = '0; m_filt = '0;
            m_irq = 1'b0; m_since = 0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            ev = '0;
            for (int i = 0; i < W; i++) begin
                if (s_lvl[i])      hit = (sync_old[i] == s_pol[i]);
                else if (s_pol[i]) hit = sync_old[i] && !m_prev[i];
                else               hit = !sync_old[i] && m_prev[i];
                ev[i] = hit && s_oe[i] && s_en[i] && done;
            end
            irq_new  = |(m_status & s_en);
            m_status = (m_status & ~s_clr) | ev;
            m_irq    = irq_new;
            m_prev   = sync_old;
            m_raw    = raw_new;
`ifdef GPIO_IN_DEBOUNCE_EN
            for (int i = 0; i < W; i++) begin
                if (raw_old[i] != m_filt[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_filt[i] = raw_old[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_sync = m_filt;
`else
            m_sync = raw_new;
`endif
            if (m_since < WARM) m_since++;
        end
        e.sync   = m_sync;
        e.status = m_status;
        e.irq    = m_irq;
        q_exp.push_back(e);
    endtask

    task automatic step(input int n = 1);
        for (int c = 0; c < n; c++) begin
            @(posedge pclk);
            model_edge();
            #1;
        end
    endtask

    task automatic pulse_clr(input gpio_vec_t m);
        s_clr = m;
        step();
        s_clr = '0;
    endtask

    // Monitor: the DUT presents a result every cycle; compare mid-cycle.
    always @(negedge pclk) begin
        if (q_exp.size() != 0) begin
            exp_t e;
            e = q_exp.pop_front();
            n_vec++;
            if (d_sync !== e.sync) begin
                n_err++;
                $display("FAIL sync_in t=%0t got %h want %h", $time, d_sync, e.sync);
            end
            if (d_status !== e.status) begin
                n_err++;
                $display("FAIL int_status t=%0t got %h want %h", $time, d_status, e.status);
            end
            if (d_irq !== e.irq) begin
                n_err++;
                $display("FAIL irq t=%0t got %b want %b", $time, d_irq, e.irq);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t run did not complete", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        m_since = 0;
        for (int i = 0; i < S; i++) begin
            pin_hist.push_back('0);
            rst_hist.push_back(1'b1);
        end

        // Pins high through reset, rising-edge mode: no spurious status.
        s_rst = 1'b1; s_pin = '1; s_oe = '1; s_en = '1;
        s_lvl = '0;   s_pol = '1; s_clr = '0;
        step(2);
        s_rst = 1'b0;
        step(WARM + 20);

        // Pin 3 rise, then clear.
        s_pin = '0;
        step(8);
        s_pin[3] = 1'b1;
        step(6);
        pulse_clr(16'h0008);
        step(4);

        // Pin 5 level-high: clear ineffective while high, effective after drop.
        s_lvl[5] = 1'b1;
        s_pin[5] = 1'b1;
        step(6);
        pulse_clr(16'h0020);
        step(3);
        s_pin[5] = 1'b0;
        step(5);
        pulse_clr(16'h0020);
        step(3);
        s_lvl[5] = 1'b0;

        // Pin 7 falling edge as an output pin, then as input with coincident clear.
        s_pol[7] = 1'b0;
        s_pin[7] = 1'b1;
        step(6);
        s_oe[7] = 1'b0;
        s_pin[7] = 1'b0;
        step(8);
        s_oe[7] = 1'b1;
        s_pin[7] = 1'b1;
        step(8);
        s_pin[7] = 1'b0;
        step(S);
        pulse_clr(16'h0080);
        step(4);

        // Masking pin 2 keeps its status but drops irq; unmasking restores irq.
        s_clr = '1;
        step();
        s_clr = '0;
        s_pin[2] = 1'b1;
        step(6);
        s_en[2] = 1'b0;
        step(4);
        s_en[2] = 1'b1;
        step(4);

        // Short glitch then sustained high on pin 0.
        s_pin[0] = 1'b1;
        step(3);
        s_pin[0] = 1'b0;
        step(10);
        s_pin[0] = 1'b1;
        step(12);

        // Reset mid-operation with status pending.
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        step(WARM + 6);

        // Random traffic: slowly toggling pins, occasional config/reset changes.
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(7) == 0) s_pin[b] = ~s_pin[b];
            end
            if ($urandom_range(31) == 0) s_oe  = gpio_vec_t'($urandom) | gpio_vec_t'($urandom);
            if ($urandom_range(31) == 0) s_en  = gpio_vec_t'($urandom);
            if ($urandom_range(63) == 0) s_lvl = gpio_vec_t'($urandom) & gpio_vec_t'($urandom);
            if ($urandom_range(31) == 0) s_pol = gpio_vec_t'($urandom);
            s_clr = ($urandom_range(3) == 0) ? gpio_vec_t'($urandom) : '0;
            s_rst = ($urandom_range(399) == 0);
            step();
        end
        s_rst = 1'b0;
        s_clr = '0;
        step(4);

        @(negedge pclk);
        @(negedge pclk);
        if (q_exp.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d want 0", q_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
